// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the Ethernet packet FIFO read-side controller.
package eth_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam int WORD_BYTES    = 4;
  localparam int MAX_UDP_WORDS = 368;
  localparam int LVL_W         = 11;
  localparam int BYTE_NUM_W    = 16;

  // Word count to byte count: x4, zero-extended to the byte-count width.
  function automatic logic [BYTE_NUM_W-1:0] words_to_bytes(input logic [LVL_W-1:0] words);
    return {{(BYTE_NUM_W-LVL_W-2){1'b0}}, words, 2'b00};
  endfunction

endpackage

// File: rtl/eth_pkt_flush_timer.sv
// Idle timer: counts cycles while run is high, saturating at TIMEOUT_CYC-1.
// expired is a flop decode, so it is safe to feed back into the clear logic.
module eth_pkt_flush_timer #(
  parameter int TIMEOUT_CYC = 125000
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/eth_pkt_tx_ctrl.sv
// Frames packet-FIFO contents into UDP payloads: full packets when enough data is
// queued, short packets after an idle timeout; words stream out on tx_req.
module eth_pkt_tx_ctrl
  import eth_pkt_pkg::*;
#(
  parameter int PKT_WORDS   = 256,
  parameter int TIMEOUT_CYC = 125000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [31:0]           fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [LVL_W-1:0]      fifo_rd_water_level,
  output logic                  fifo_rd_en,
  output logic                  tx_start_en,
  output logic [BYTE_NUM_W-1:0] tx_byte_num,
  input  logic                  tx_req,
  output logic [31:0]           tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  underrun,
  output logic [15:0]           pkt_cnt
);

  localparam logic [LVL_W-1:0] PKT_LEN = LVL_W'(PKT_WORDS);

  tx_state_t        state;
  logic [LVL_W-1:0] len;
  logic [LVL_W-1:0] word_cnt;
  logic             rd_en_q;
  logic [31:0]      data_hold;
  logic [15:0]      pkt_cnt_q;

  logic level_nz, level_full, timer_exp, go_full, go_flush, rd_en, last_rd, underrun_evt;

  assign level_nz   = |fifo_rd_water_level;
  assign level_full = (fifo_rd_water_level >= PKT_LEN);
  assign go_full    = (state == IDLE) && level_full;
  assign go_flush   = (state == IDLE) && level_nz && timer_exp;

  eth_pkt_flush_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_flush_timer (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .run     ((state == IDLE) && level_nz),
    .clr     ((state != IDLE) || !level_nz || go_full || go_flush),
    .expired (timer_exp)
  );

  assign rd_en        = (state == SEND) && tx_req && !fifo_empty && (word_cnt < len);
  assign last_rd      = rd_en && (word_cnt == (len - 1'b1));
  assign underrun_evt = tx_req && (((state == SEND) && fifo_empty) || (state == WAIT_DONE));

  assign fifo_rd_en = rd_en;
  assign pkt_cnt    = pkt_cnt_q;
  // FIFO data arrives the cycle after the read, which is exactly when the UDP engine
  // samples it; pass it through then and replay the captured word otherwise.
  assign tx_data    = rd_en_q ? fifo_rd_data : data_hold;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state       <= IDLE;
      len         <= '0;
      word_cnt    <= '0;
      rd_en_q     <= 1'b0;
      data_hold   <= '0;
      pkt_cnt_q   <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      tx_start_en <= 1'b0;
      rd_en_q     <= rd_en;
      if (rd_en_q) begin
        data_hold <= fifo_rd_data;
      end
      if (underrun_evt) begin
        underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (go_full || go_flush) begin
            len         <= go_full ? PKT_LEN : fifo_rd_water_level;
            tx_byte_num <= words_to_bytes(go_full ? PKT_LEN : fifo_rd_water_level);
            tx_start_en <= 1'b1;
            pkt_cnt_q   <= pkt_cnt_q + 1'b1;
            word_cnt    <= '0;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          state <= SEND;
        end
        SEND: begin
          if (rd_en) begin
            word_cnt <= word_cnt + 1'b1;
          end
          // An early tx_done abandons the packet; unread words stay queued.
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_rd) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
